operand_stream_feeder: RTL and testbench

OPERAND_STREAM_FEEDER -- requirements
Module: operand_stream_feeder

---
 rtl/operand_stream_feeder.sv | 124 ++++++++++++
 tb/tb_operand_stream_feeder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_stream_feeder.sv
// Operand stream feeder: buffers A columns and B rows, then streams
// them in reverse slot order to a systolic multiplier with backpressure.
module operand_stream_feeder #(
  parameter int DATA_WIDTH   = 8,
  parameter int N            = 4,
  parameter int K_MAX        = 16,
  parameter int COUNTER_BITS = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic                         load_sel,
  input  logic [$clog2(K_MAX)-1:0]     load_k,
  input  logic [N*DATA_WIDTH-1:0]      load_data,
  input  logic                         start,
  input  logic [COUNTER_BITS-1:0]      len,
  output logic                         busy,
  output logic                         done,
  output logic                         len_error,
  output logic                         mm_a_valid,
  output logic                         mm_b_valid,
  input  logic                         mm_input_ready,
  output logic [COUNTER_BITS-1:0]      mm_len_input,
  output logic [N*DATA_WIDTH-1:0]      mm_a_data,
  output logic [N*DATA_WIDTH-1:0]      mm_b_data
);

  localparam int KW = $clog2(K_MAX);
  localparam int VW = N * DATA_WIDTH;
  localparam logic [COUNTER_BITS-1:0] KMAX_C = COUNTER_BITS'(K_MAX);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t                  state_q, state_d;
  logic [KW-1:0]           idx_q, idx_d;
  logic [COUNTER_BITS-1:0] len_q, len_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    wr_en;
  logic                    len_ok;

  logic [VW-1:0] a_buf [K_MAX];
  logic [VW-1:0] b_buf [K_MAX];

  assign len_ok = (len != '0) && (len <= KMAX_C);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        wr_en = load_valid;
        if (start) begin
          if (len_ok) begin
            state_d = STREAM;
            len_d   = len;
            idx_d   = KW'(len - COUNTER_BITS'(1));
          end else begin
            err_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (mm_input_ready) begin
          if (idx_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q - KW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Writes land at the start edge, so they are visible on the first beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < K_MAX; i++) begin
        a_buf[i] <= '0;
        b_buf[i] <= '0;
      end
    end else if (wr_en) begin
      if (load_sel) b_buf[load_k] <= load_data;
      else          a_buf[load_k] <= load_data;
    end
  end

  assign load_ready   = (state_q == IDLE);
  assign busy         = (state_q == STREAM);
  assign mm_a_valid   = busy;
  assign mm_b_valid   = busy;
  assign done         = done_q;
  assign len_error    = err_q;
  assign mm_len_input = busy ? len_q : '0;
  assign mm_a_data    = busy ? a_buf[idx_q] : '0;
  assign mm_b_data    = busy ? b_buf[idx_q] : '0;

endmodule

// File: tb/tb_operand_stream_feeder.sv
// Directed bench for operand_stream_feeder with N=4, DATA_WIDTH=8.
// Outputs are sampled 1ns after each rising edge.
module tb_operand_stream_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic        load_sel;
  logic [3:0]  load_k;
  logic [31:0] load_data;
  logic        start;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic        len_error;
  logic        mm_a_valid;
  logic        mm_b_valid;
  logic        mm_input_ready;
  logic [15:0] mm_len_input;
  logic [31:0] mm_a_data;
  logic [31:0] mm_b_data;

  int checks = 0;
  int errors = 0;

  operand_stream_feeder dut (
    .clk(clk),
    .reset(reset),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_sel(load_sel),
    .load_k(load_k),
    .load_data(load_data),
    .start(start),
    .len(len),
    .busy(busy),
    .done(done),
    .len_error(len_error),
    .mm_a_valid(mm_a_valid),
    .mm_b_valid(mm_b_valid),
    .mm_input_ready(mm_input_ready),
    .mm_len_input(mm_len_input),
    .mm_a_data(mm_a_data),
    .mm_b_data(mm_b_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pk(int e0, int e1, int e2, int e3);
    return {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  function automatic logic [31:0] a_of(int k);
    return pk(k, k + 1, k + 2, k + 3);
  endfunction

  function automatic logic [31:0] b_of(int k);
    return pk(10 * k, 10 * k + 1, 10 * k + 2, 10 * k + 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic sel, input int k, input logic [31:0] d);
    load_valid = 1'b1;
    load_sel   = sel;
    load_k     = 4'(k);
    load_data  = d;
    step();
    load_valid = 1'b0;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_av"}, 32'(mm_a_valid), 32'd0);
    chk({tag, "_bv"}, 32'(mm_b_valid), 32'd0);
    chk({tag, "_len"}, 32'(mm_len_input), 32'd0);
    chk({tag, "_ad"}, mm_a_data, 32'd0);
    chk({tag, "_bd"}, mm_b_data, 32'd0);
    chk({tag, "_lr"}, 32'(load_ready), 32'd1);
  endtask

  task automatic beat_chk(input string tag, input logic [31:0] ea,
                          input logic [31:0] eb, input int l);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_av"}, 32'(mm_a_valid), 32'd1);
    chk({tag, "_bv"}, 32'(mm_b_valid), 32'd1);
    chk({tag, "_lr"}, 32'(load_ready), 32'd0);
    chk({tag, "_len"}, 32'(mm_len_input), 32'(l));
    chk({tag, "_ad"}, mm_a_data, ea);
    chk({tag, "_bd"}, mm_b_data, eb);
  endtask

  initial begin
    logic [5:0] pat;
    int         expk [6];
    reset          = 1'b1;
    load_valid     = 1'b0;
    load_sel       = 1'b0;
    load_k         = '0;
    load_data      = '0;
    start          = 1'b0;
    len            = '0;
    mm_input_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    idle_chk("rst");
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(len_error), 32'd0);

    // Basic run, ready held high
    for (int k = 0; k < 3; k++) begin
      load(1'b0, k, a_of(k));
      load(1'b1, k, b_of(k));
    end
    start = 1'b1;
    len = 16'd3;
    mm_input_ready = 1'b1;
    step();
    start = 1'b0;
    beat_chk("r1_b0", a_of(2), b_of(2), 3);
    step();
    beat_chk("r1_b1", a_of(1), b_of(1), 3);
    step();
    beat_chk("r1_b2", a_of(0), b_of(0), 3);
    chk("r1_nodone", 32'(done), 32'd0);
    step();
    chk("r1_done", 32'(done), 32'd1);
    idle_chk("r1_end");
    step();
    chk("r1_done_off", 32'(done), 32'd0);

    // Backpressure: ready pattern 1,0,0,1,0,1
    pat = 6'b101001;
    expk = '{2, 1, 1, 1, 0, 0};
    start = 1'b1;
    len = 16'd3;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mm_input_ready = pat[i];
      beat_chk($sformatf("bp_c%0d", i), a_of(expk[i]), b_of(expk[i]), 3);
      chk($sformatf("bp_nd%0d", i), 32'(done), 32'd0);
      step();
    end
    chk("bp_done", 32'(done), 32'd1);
    idle_chk("bp_end");

    // Rejected lengths
    step();
    start = 1'b1;
    len = 16'd0;
    step();
    start = 1'b0;
    chk("e0_err", 32'(len_error), 32'd1);
    idle_chk("e0");
    step();
    chk("e0_err_off", 32'(len_error), 32'd0);
    idle_chk("e0b");
    start = 1'b1;
    len = 16'd17;
    step();
    start = 1'b0;
    chk("e17_err", 32'(len_error), 32'd1);
    idle_chk("e17");
    step();
    chk("e17_err_off", 32'(len_error), 32'd0);
    idle_chk("e17b");

    // Load and start in the same cycle
    mm_input_ready = 1'b0;
    load_valid = 1'b1;
    load_sel = 1'b0;
    load_k = 4'd0;
    load_data = pk(5, 5, 5, 5);
    start = 1'b1;
    len = 16'd1;
    step();
    load_valid = 1'b0;
    start = 1'b0;
    beat_chk("ls_b0", pk(5, 5, 5, 5), b_of(0), 1);
    mm_input_ready = 1'b1;
    step();
    chk("ls_done", 32'(done), 32'd1);
    idle_chk("ls_end");

    // Reset mid-run
    start = 1'b1;
    len = 16'd4;
    step();
    start = 1'b0;
    beat_chk("rr_b0", 32'd0, 32'd0, 4);
    step();
    beat_chk("rr_b1", a_of(2), b_of(2), 4);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle_chk("rr_post");
    chk("rr_nodone", 32'(done), 32'd0);
    step();
    chk("rr_nodone2", 32'(done), 32'd0);
    start = 1'b1;
    len = 16'd4;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat_chk($sformatf("rr_z%0d", i), 32'd0, 32'd0, 4);
      step();
    end
    chk("rr_zdone", 32'(done), 32'd1);

    // Re-stream without reload, loads ignored while streaming
    load(1'b0, 0, a_of(0));
    load(1'b0, 1, a_of(1));
    load(1'b1, 0, b_of(0));
    load(1'b1, 1, b_of(1));
    start = 1'b1;
    len = 16'd2;
    step();
    start = 1'b0;
    beat_chk("rs1_b0", a_of(1), b_of(1), 2);
    step();
    beat_chk("rs1_b1", a_of(0), b_of(0), 2);
    step();
    chk("rs1_done", 32'(done), 32'd1);
    mm_input_ready = 1'b0;
    start = 1'b1;
    len = 16'd2;
    step();
    start = 1'b0;
    beat_chk("rs2_b0", a_of(1), b_of(1), 2);
    load_valid = 1'b1;
    load_sel = 1'b0;
    load_k = 4'd1;
    load_data = 32'hffff_ffff;
    step();
    beat_chk("rs2_h0", a_of(1), b_of(1), 2);
    load_sel = 1'b1;
    load_k = 4'd0;
    load_data = 32'heeee_eeee;
    mm_input_ready = 1'b1;
    step();
    load_valid = 1'b0;
    beat_chk("rs2_b1", a_of(0), b_of(0), 2);
    step();
    chk("rs2_done", 32'(done), 32'd1);
    idle_chk("rs2_end");
    mm_input_ready = 1'b0;
    start = 1'b1;
    len = 16'd2;
    step();
    start = 1'b0;
    beat_chk("rs3_b0", a_of(1), b_of(1), 2);
    mm_input_ready = 1'b1;
    step();
    beat_chk("rs3_b1", a_of(0), b_of(0), 2);
    step();
    chk("rs3_done", 32'(done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
